cpu7_ifu_ibiu: RTL and testbench



---
 rtl/cpu7_ifu_ibiu_pkg.sv | 19 +
 rtl/cpu7_ifu_ibiu_rsp.sv | 36 +++
 rtl/cpu7_ifu_ibiu.sv | 182 ++++++++++++++++++
 tb/tb_cpu7_ifu_ibiu.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu7_ifu_ibiu_pkg.sv
// rtl/cpu7_ifu_ibiu_pkg.sv - shared state encoding, AXI and exccode constants for the ibiu
package cpu7_ifu_ibiu_pkg;

  typedef enum logic [2:0] {
    IBIU_IDLE  = 3'd0,
    IBIU_ADDR  = 3'd1,
    IBIU_DATA  = 3'd2,
    IBIU_DRAIN = 3'd3,
    IBIU_EXC   = 3'd4
  } ibiu_state_e;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam logic [5:0] ECODE_ADEF   = 6'h08;
  localparam logic [5:0] ECODE_BUSERR = 6'h08;

endpackage

// File: rtl/cpu7_ifu_ibiu_rsp.sv
// rtl/cpu7_ifu_ibiu_rsp.sv - registered fetch result stage with cancel suppression
module cpu7_ifu_ibiu_rsp #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              load_i,
  input  logic              cancel_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic              ex_i,
  input  logic [5:0]        exccode_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              ex_o,
  output logic [5:0]        exccode_o
);

  logic fire;
  assign fire = load_i & ~cancel_i;

  // One-cycle result pulse; fields read as zero outside the pulse
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      valid_o   <= 1'b0;
      rdata_o   <= '0;
      ex_o      <= 1'b0;
      exccode_o <= '0;
    end else begin
      valid_o   <= fire;
      rdata_o   <= fire ? rdata_i : '0;
      ex_o      <= fire & ex_i;
      exccode_o <= fire ? exccode_i : 6'd0;
    end
  end

endmodule

// File: rtl/cpu7_ifu_ibiu.sv
// rtl/cpu7_ifu_ibiu.sv - instruction bus interface unit, optional macro CPU7_IBIU_ALIGN_CHK_EN
module cpu7_ifu_ibiu
  import cpu7_ifu_ibiu_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [3:0]        ARID       = 4'd0,
  parameter logic [5:0]        EXC_ADEF   = ECODE_ADEF,
  parameter logic [5:0]        EXC_BUSERR = ECODE_BUSERR,
  parameter logic [ADDR_W-1:0] UC_BASE    = 32'ha000_0000,
  parameter logic [ADDR_W-1:0] UC_MASK    = 32'he000_0000
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_cancel,
  output logic              inst_ack,
  output logic              inst_valid_f,
  output logic [DATA_W-1:0] inst_rdata_f,
  output logic              inst_ex,
  output logic [5:0]        inst_exccode,
  output logic              inst_uncache,
  output logic [1:0]        inst_count,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [3:0]        arid,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast
);

  ibiu_state_e       state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              uncache_q;
  logic              cancel_q;
  logic              arvalid_q;
  logic              rready_q;

  logic              rsp_load;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_ex;
  logic [5:0]        rsp_code;
  logic [ADDR_W-1:0] ar_word;
  logic              unused_ok;

  // Acceptance is only possible from IDLE and never alongside a cancel
  assign inst_ack = (state_q == IBIU_IDLE) & inst_req & ~inst_cancel;

`ifdef CPU7_IBIU_ALIGN_CHK_EN
  assign ar_word   = addr_q;
  assign unused_ok = rlast;
`else
  assign ar_word   = {addr_q[ADDR_W-1:2], 2'b00};
  assign unused_ok = ^{rlast, addr_q[1:0], EXC_ADEF};
`endif

  assign arvalid      = arvalid_q;
  assign araddr       = arvalid_q ? ar_word : '0;
  assign arid         = ARID;
  assign arlen        = 8'd0;
  assign arsize       = AXI_SIZE_4B;
  assign arburst      = AXI_BURST_INCR;
  assign rready       = rready_q;
  assign inst_uncache = uncache_q;
  assign inst_count   = {1'b0, inst_valid_f};

  // Result capture: bus response in DATA, local address fault in EXC
  always_comb begin
    rsp_load = 1'b0;
    rsp_data = '0;
    rsp_ex   = 1'b0;
    rsp_code = 6'd0;
    case (state_q)
      IBIU_DATA: begin
        if (rvalid) begin
          rsp_load = 1'b1;
          rsp_data = rdata;
          rsp_ex   = (rresp != AXI_RESP_OKAY);
          rsp_code = (rresp != AXI_RESP_OKAY) ? EXC_BUSERR : 6'd0;
        end
      end
`ifdef CPU7_IBIU_ALIGN_CHK_EN
      IBIU_EXC: begin
        rsp_load = 1'b1;
        rsp_ex   = 1'b1;
        rsp_code = EXC_ADEF;
      end
`endif
      default: ;
    endcase
  end

  // Fetch sequencing; AR cannot be withdrawn, so a cancel in ADDR is remembered and drained later
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q   <= IBIU_IDLE;
      addr_q    <= '0;
      uncache_q <= 1'b0;
      cancel_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      case (state_q)
        IBIU_IDLE: begin
          uncache_q <= 1'b0;
          cancel_q  <= 1'b0;
          if (inst_ack) begin
            addr_q    <= inst_addr;
            uncache_q <= ((inst_addr & UC_MASK) == UC_BASE);
`ifdef CPU7_IBIU_ALIGN_CHK_EN
            if (inst_addr[1:0] != 2'b00) begin
              state_q <= IBIU_EXC;
            end else begin
              state_q   <= IBIU_ADDR;
              arvalid_q <= 1'b1;
            end
`else
            state_q   <= IBIU_ADDR;
            arvalid_q <= 1'b1;
`endif
          end
        end
        IBIU_ADDR: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            cancel_q  <= 1'b0;
            state_q   <= (inst_cancel | cancel_q) ? IBIU_DRAIN : IBIU_DATA;
          end else if (inst_cancel) begin
            cancel_q <= 1'b1;
          end
        end
        IBIU_DATA: begin
          if (rvalid) begin
            rready_q <= 1'b0;
            state_q  <= IBIU_IDLE;
          end else if (inst_cancel) begin
            state_q <= IBIU_DRAIN;
          end
        end
        IBIU_DRAIN: begin
          if (rvalid) begin
            rready_q <= 1'b0;
            state_q  <= IBIU_IDLE;
          end
        end
        IBIU_EXC: begin
          state_q <= IBIU_IDLE;
        end
        default: begin
          state_q   <= IBIU_IDLE;
          arvalid_q <= 1'b0;
          rready_q  <= 1'b0;
        end
      endcase
    end
  end

  cpu7_ifu_ibiu_rsp #(
    .DATA_W(DATA_W)
  ) u_rsp (
    .clk      (clk),
    .rst_l    (rst_l),
    .load_i   (rsp_load),
    .cancel_i (inst_cancel),
    .rdata_i  (rsp_data),
    .ex_i     (rsp_ex),
    .exccode_i(rsp_code),
    .valid_o  (inst_valid_f),
    .rdata_o  (inst_rdata_f),
    .ex_o     (inst_ex),
    .exccode_o(inst_exccode)
  );

endmodule

// File: tb/tb_cpu7_ifu_ibiu.sv
// tb/tb_cpu7_ifu_ibiu.sv - self-checking bench for cpu7_ifu_ibiu against a transaction-level model
module tb_cpu7_ifu_ibiu;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_cancel;
  logic        inst_ack;
  logic        inst_valid_f;
  logic [31:0] inst_rdata_f;
  logic        inst_ex;
  logic [5:0]  inst_exccode;
  logic        inst_uncache;
  logic [1:0]  inst_count;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cpu7_ifu_ibiu dut (
    .clk         (clk),
    .rst_l       (rst_l),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_cancel (inst_cancel),
    .inst_ack    (inst_ack),
    .inst_valid_f(inst_valid_f),
    .inst_rdata_f(inst_rdata_f),
    .inst_ex     (inst_ex),
    .inst_exccode(inst_exccode),
    .inst_uncache(inst_uncache),
    .inst_count  (inst_count),
    .arvalid     (arvalid),
    .arready     (arready),
    .araddr      (araddr),
    .arid        (arid),
    .arlen       (arlen),
    .arsize      (arsize),
    .arburst     (arburst),
    .rvalid      (rvalid),
    .rready      (rready),
    .rdata       (rdata),
    .rresp       (rresp),
    .rlast       (rlast)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic is_uc(input logic [31:0] a);
    return (a & 32'he000_0000) == 32'ha000_0000;
  endfunction

  task automatic drive_quiet();
    inst_req    = 1'b0;
    inst_addr   = 32'h0;
    inst_cancel = 1'b0;
    arready     = 1'b0;
    rvalid      = 1'b0;
    rdata       = 32'h0;
    rresp       = 2'b00;
    rlast       = 1'b0;
  endtask

  // One fetch as seen by fdp and the AXI slave. Busy cycles are numbered from the
  // cycle after ack: AR phase is 0..ar_dly, R phase follows with rvalid on the last.
  // cxl_at >= 0 pulses inst_cancel in that busy cycle and the fetch must vanish.
  task automatic fetch(input logic [31:0] a, input int ar_dly, input int r_dly,
                       input int cxl_at, input logic [1:0] resp, input logic [31:0] d);
    int   last;
    logic killed;
    logic [31:0] exp_ar;
    last   = ar_dly + 1 + r_dly;
    exp_ar = {a[31:2], 2'b00};

    @(negedge clk);
    inst_req = 1'b1; inst_addr = a; inst_cancel = 1'b0;
    #1 chk("ack", 32'(inst_ack), 32'd1);

`ifdef CPU7_IBIU_ALIGN_CHK_EN
    if (a[1:0] != 2'b00) begin
      killed = (cxl_at == 0);
      @(negedge clk);
      inst_req = 1'($urandom_range(0, 1)); inst_addr = $urandom; inst_cancel = killed;
      #1;
      chk("exc_ack", 32'(inst_ack), 32'd0);
      chk("exc_arvalid", 32'(arvalid), 32'd0);
      chk("exc_valid_early", 32'(inst_valid_f), 32'd0);
      @(negedge clk);
      drive_quiet();
      #1;
      chk("exc_valid", 32'(inst_valid_f), 32'(!killed));
      chk("exc_ex", 32'(inst_ex), 32'(!killed));
      chk("exc_code", 32'(inst_exccode), killed ? 32'h0 : 32'h08);
      chk("exc_data", inst_rdata_f, 32'h0);
      return;
    end
`endif

    killed = (cxl_at >= 0);
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      inst_req    = 1'($urandom_range(0, 1));
      inst_addr   = $urandom;
      inst_cancel = (k == cxl_at);
      arready     = (k == ar_dly);
      rvalid      = (k == last);
      rdata       = (k == last) ? d : $urandom;
      rresp       = (k == last) ? resp : 2'($urandom);
      #1;
      chk("busy_ack", 32'(inst_ack), 32'd0);
      chk("busy_valid", 32'(inst_valid_f), 32'd0);
      chk("busy_uncache", 32'(inst_uncache), 32'(is_uc(a)));
      if (k <= ar_dly) begin
        chk("ar_valid", 32'(arvalid), 32'd1);
        chk("ar_addr", araddr, exp_ar);
        chk("ar_rready", 32'(rready), 32'd0);
      end else begin
        chk("r_arvalid", 32'(arvalid), 32'd0);
        chk("r_rready", 32'(rready), 32'd1);
      end
    end

    @(negedge clk);
    drive_quiet();
    #1;
    chk("done_valid", 32'(inst_valid_f), 32'(!killed));
    chk("done_count", 32'(inst_count), killed ? 32'd0 : 32'd1);
    chk("done_data", inst_rdata_f, killed ? 32'h0 : d);
    chk("done_ex", 32'(inst_ex), (killed || resp == 2'b00) ? 32'd0 : 32'd1);
    chk("done_code", 32'(inst_exccode), (killed || resp == 2'b00) ? 32'h0 : 32'h08);
    chk("done_arvalid", 32'(arvalid), 32'd0);
    chk("done_rready", 32'(rready), 32'd0);
  endtask

  initial begin
    logic [7:0] regions [4];
    regions[0] = 8'h1c; regions[1] = 8'ha0; regions[2] = 8'hbf; regions[3] = 8'h80;

    rst_l = 1'b0;
    drive_quiet();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_rready", 32'(rready), 32'd0);
    chk("rst_valid", 32'(inst_valid_f), 32'd0);
    chk("rst_arid", 32'(arid), 32'd0);
    chk("rst_arlen", 32'(arlen), 32'd0);
    chk("rst_arsize", 32'(arsize), 32'd2);
    chk("rst_arburst", 32'(arburst), 32'd1);
    rst_l = 1'b1;

    // basic fetch, bus error, AR backpressure with cancel, cancel while in DATA
    fetch(32'h1c00_0000, 0, 2, -1, 2'b00, 32'h0280_0421);
    fetch(32'h1c00_0004, 0, 1, -1, 2'b10, 32'h1234_5678);
    fetch(32'h1c00_0008, 4, 1, 2, 2'b00, 32'h5555_aaaa);
    fetch(32'h1c00_000c, 0, 3, 2, 2'b00, 32'hdead_beef);
    fetch(32'h1c00_0010, 0, 0, -1, 2'b00, 32'h0011_2233);
    fetch(32'ha000_1000, 1, 0, -1, 2'b00, 32'hcafe_f00d);
    fetch(32'h1c00_0002, 0, 1, -1, 2'b00, 32'h0badc0de);

    // cancel together with the request: no ack, nothing issued
    @(negedge clk);
    inst_req = 1'b1; inst_cancel = 1'b1; inst_addr = 32'h1c00_0020;
    #1 chk("same_cycle_ack", 32'(inst_ack), 32'd0);
    @(negedge clk);
    drive_quiet();
    #1;
    chk("same_cycle_arvalid", 32'(arvalid), 32'd0);
    chk("same_cycle_rready", 32'(rready), 32'd0);

    // asynchronous reset while waiting for read data
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'h1c00_0030;
    #1 chk("rst_mid_ack", 32'(inst_ack), 32'd1);
    @(negedge clk);
    inst_req = 1'b0; arready = 1'b1;
    #1 chk("rst_mid_arvalid", 32'(arvalid), 32'd1);
    @(negedge clk);
    arready = 1'b0;
    #1 chk("rst_mid_rready", 32'(rready), 32'd1);
    #2 rst_l = 1'b0;
    #1;
    chk("async_rst_rready", 32'(rready), 32'd0);
    chk("async_rst_arvalid", 32'(arvalid), 32'd0);
    chk("async_rst_uncache", 32'(inst_uncache), 32'd0);
    @(negedge clk);
    rst_l = 1'b1; rvalid = 1'b1; rdata = 32'hfeed_0001;
    #1 chk("late_rready", 32'(rready), 32'd0);
    @(negedge clk);
    drive_quiet();
    #1;
    chk("late_valid", 32'(inst_valid_f), 32'd0);
    chk("late_arvalid", 32'(arvalid), 32'd0);

    // randomized fetches
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      int ar_d, r_d, cx;
      a = {regions[$urandom_range(0, 3)], 24'($urandom)};
      if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
      ar_d = $urandom_range(0, 3);
      r_d  = $urandom_range(0, 3);
      cx   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, ar_d + 1 + r_d) : -1;
      fetch(a, ar_d, r_d, cx, ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
